// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair serializer.
//   FIB_W      : width of one Fibonacci number
//   fib_pair_t : one buffered pair, lo is emitted before hi
package fib_pkg;

  localparam int unsigned FIB_W = 16;

  typedef struct packed {
    logic [FIB_W-1:0] hi;
    logic [FIB_W-1:0] lo;
  } fib_pair_t;

endpackage

// File: rtl/fib_pair_serializer_if.sv
// Stream bundle for fib_pair_serializer.
//   in_valid/in_ready/in_lo/in_hi : pair input, one pair per handshake
//   out_valid/out_ready/out_data  : number output, one number per handshake
//   level                         : pairs currently stored
//   out_count                     : numbers emitted since reset, wraps at 2^16
// master drives the inputs (producer/consumer side), slave is the serializer.
interface fib_pair_serializer_if
  import fib_pkg::*;
#(
  parameter int unsigned W     = FIB_W,
  parameter int unsigned DEPTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [W-1:0]             in_lo;
  logic [W-1:0]             in_hi;
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             out_data;
  logic [$clog2(DEPTH):0]   level;
  logic [15:0]              out_count;

  modport master (
    output in_valid, in_lo, in_hi, out_ready,
    input  in_ready, out_valid, out_data, level, out_count
  );

  modport slave (
    input  in_valid, in_lo, in_hi, out_ready,
    output in_ready, out_valid, out_data, level, out_count
  );

endinterface

// File: rtl/fib_pair_fifo.sv
// Synchronous FIFO of fib_pair_t.
//   clk, rst_n : clock, asynchronous active-low reset (storage is not reset)
//   push_i     : write wdata_i (caller guarantees !full_o)
//   pop_i      : drop head entry (caller guarantees !empty_o)
//   rdata_o    : head entry, combinational from storage
//   full_o, empty_o, level_o : occupancy in pairs
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fib_pair_t              wdata_i,
  output fib_pair_t              rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  fib_pair_t             mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;

  // DEPTH is a power of two, so plain pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/fib_pair_serializer.sv
// Buffers Fibonacci pairs from a two-per-cycle producer and emits them one number per
// handshake in order lo, hi, lo, hi, ...
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fib_pair_serializer_if slave (pair input, number output, level, out_count)
// W must equal fib_pkg::FIB_W since the buffered pair type is fixed by the package.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned W     = FIB_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fib_pair_serializer_if.slave  bus
);

  fib_pair_t   wdata;
  fib_pair_t   head;
  logic        full;
  logic        empty;
  logic        push;
  logic        out_fire;
  logic        pop_pair;
  logic        half_q, half_d;
  logic [15:0] out_count_q, out_count_d;

  // No pass-through when full: a pop in the same cycle frees space only next cycle.
  assign push     = bus.in_valid && !full;
  assign out_fire = !empty && bus.out_ready;
  // The entry leaves the FIFO only once its hi half has been taken.
  assign pop_pair = out_fire && half_q;

  assign wdata.lo = FIB_W'(bus.in_lo);
  assign wdata.hi = FIB_W'(bus.in_hi);

  fib_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop_pair),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.level)
  );

  always_comb begin
    half_d      = half_q;
    out_count_d = out_count_q;
    if (out_fire) begin
      half_d      = ~half_q;
      out_count_d = out_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q      <= 1'b0;
      out_count_q <= '0;
    end else begin
      half_q      <= half_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = half_q ? head.hi[W-1:0] : head.lo[W-1:0];
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Self-checking bench for fib_pair_serializer. Reference model: a queue of numbers still
// owed downstream, in emission order; stored pairs = ceil(queue size / 2).
module tb_fib_pair_serializer;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fib_pair_serializer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  fib_pair_serializer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_cnt  = 0;

  function automatic int exp_level();
    return (exp_q.size() + 1) / 2;
  endfunction

  // Called at the falling edge; moves to one time unit after the next rising edge and
  // applies the handshakes the model says happened there.
  task automatic advance();
    bit ai;
    bit ao;
    ai = bus.in_valid && (exp_level() != DEPTH);
    ao = bus.out_ready && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (ao) begin
      void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    if (ai) begin
      exp_q.push_back(int'(bus.in_lo));
      exp_q.push_back(int'(bus.in_hi));
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_lo     = '0;
    bus.in_hi     = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #4;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.level !== 3'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level);
    end
    n_checks++;
    if (bus.out_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_out_count: got %0d expected 0", bus.out_count);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    int lo_t[4]  = '{1, 2, 5, 13};
    int hi_t[4]  = '{1, 3, 8, 21};
    int seq_t[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_lo    = W'(lo_t[i]);
      bus.in_hi    = W'(hi_t[i]);
      #4;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.level !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_accept[%0d]: got ready=%0b level=%0d expected ready=1 level=%0d",
                 i, bus.in_ready, bus.level, i);
      end
      advance();
    end
    bus.in_valid = 1'b0;
    #4;
    n_checks++;
    if (bus.level !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got level=%0d ready=%0b expected level=4 ready=0",
               bus.level, bus.in_ready);
    end
    advance();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #4;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(seq_t[i])
          || bus.in_ready !== (i >= 2)) begin
        n_fail++;
        $display("FAIL drain[%0d]: got valid=%0b data=%0d ready=%0b expected 1 %0d %0b",
                 i, bus.out_valid, bus.out_data, bus.in_ready, seq_t[i], (i >= 2));
      end
      advance();
    end
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.out_count !== 16'd8) begin
      n_fail++;
      $display("FAIL drain_end: got valid=%0b level=%0d count=%0d expected 0 0 8",
               bus.out_valid, bus.level, bus.out_count);
    end
    advance();
    bus.out_ready = 1'b0;
  endtask

  // Emulates the double-rate generator upstream and checks against a single-rate sequence.
  task automatic test_fib_stream();
    int fib[20];
    int k   = 0;
    int got = 0;
    int a   = 1;
    int b   = 1;
    int t;
    fib[0] = 1;
    fib[1] = 1;
    for (int i = 2; i < 20; i++) fib[i] = fib[i-1] + fib[i-2];
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      bus.in_valid = (k < 10);
      if (k < 10) begin
        bus.in_lo = W'(fib[2*k]);
        bus.in_hi = W'(fib[2*k+1]);
      end
      #4;
      if (bus.out_valid === 1'b1) begin
        n_checks++;
        if (bus.out_data !== W'(a)) begin
          n_fail++; $display("FAIL fib_stream[%0d]: got %0d expected %0d", got, bus.out_data, a);
        end
        got++;
        t = a + b;
        a = b;
        b = t;
      end
      if (bus.in_valid && exp_level() != DEPTH) k++;
      advance();
    end
    n_checks++;
    if (got != 20) begin
      n_fail++; $display("FAIL fib_stream_count: got %0d numbers expected 20", got);
    end
    bus.in_valid = 1'b0;
    #4;
    n_checks++;
    if (bus.out_count !== 16'd20 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fib_stream_end: got count=%0d valid=%0b expected 20 0",
               bus.out_count, bus.out_valid);
    end
    advance();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random_stall();
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      bus.in_valid  = (c < 260) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_lo     = W'($urandom);
      bus.in_hi     = W'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      #4;
      n_checks++;
      if (bus.out_valid !== (exp_q.size() != 0) || bus.level !== 3'(exp_level())
          || bus.in_ready !== (exp_level() != DEPTH)) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got valid=%0b level=%0d ready=%0b expected %0b %0d %0b",
                 c, bus.out_valid, bus.level, bus.in_ready, (exp_q.size() != 0),
                 exp_level(), (exp_level() != DEPTH));
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (bus.out_data !== W'(exp_q[0])) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %0d expected %0d", c, bus.out_data, exp_q[0]);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.out_data !== prev_data) begin
          n_fail++;
          $display("FAIL rand_stall_hold[%0d]: got %0d expected %0d", c, bus.out_data, prev_data);
        end
      end
      prev_stall = (exp_q.size() != 0) && !bus.out_ready;
      prev_data  = bus.out_data;
      advance();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      #4;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(exp_q[0])) begin
        n_fail++;
        $display("FAIL rand_drain[%0d]: got valid=%0b data=%0d expected 1 %0d",
                 c, bus.out_valid, bus.out_data, exp_q[0]);
      end
      advance();
    end
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rand_end: got valid=%0b count=%0d expected 0 %0d",
               bus.out_valid, bus.out_count, exp_cnt);
    end
    advance();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_lo    = W'(100 + 2 * i);
      bus.in_hi    = W'(101 + 2 * i);
      #4;
      advance();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #4;
    advance();
    bus.out_ready = 1'b0;
    #4;
    n_checks++;
    if (bus.level !== 3'd3 || bus.out_valid !== 1'b1 || bus.out_data !== 16'd101) begin
      n_fail++;
      $display("FAIL midrst_pre: got level=%0d valid=%0b data=%0d expected 3 1 101",
               bus.level, bus.out_valid, bus.out_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: got valid=%0b level=%0d ready=%0b expected 0 0 1",
               bus.out_valid, bus.level, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    bus.in_valid = 1'b1;
    bus.in_lo    = 16'd89;
    bus.in_hi    = 16'd144;
    #4;
    advance();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd89) begin
      n_fail++;
      $display("FAIL midrst_lo: got valid=%0b data=%0d expected 1 89", bus.out_valid, bus.out_data);
    end
    advance();
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd144) begin
      n_fail++;
      $display("FAIL midrst_hi: got valid=%0b data=%0d expected 1 144",
               bus.out_valid, bus.out_data);
    end
    advance();
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd2) begin
      n_fail++;
      $display("FAIL midrst_end: got valid=%0b count=%0d expected 0 2",
               bus.out_valid, bus.out_count);
    end
    advance();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_push_pop_same();
    int tail_t[3] = '{6, 7, 9};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_lo    = W'(3 + 2 * i);
      bus.in_hi    = W'(4 + 2 * i);
      #4;
      advance();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #4;
    n_checks++;
    if (bus.out_data !== 16'd3 || bus.level !== 3'd2) begin
      n_fail++;
      $display("FAIL pp_first: got data=%0d level=%0d expected 3 2", bus.out_data, bus.level);
    end
    advance();
    bus.in_valid = 1'b1;
    bus.in_lo    = 16'd7;
    bus.in_hi    = 16'd9;
    #4;
    n_checks++;
    if (bus.out_data !== 16'd4 || bus.level !== 3'd2 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_same_cycle: got data=%0d level=%0d ready=%0b expected 4 2 1",
               bus.out_data, bus.level, bus.in_ready);
    end
    advance();
    bus.in_valid = 1'b0;
    #4;
    n_checks++;
    if (bus.level !== 3'd2 || bus.out_data !== 16'd5) begin
      n_fail++;
      $display("FAIL pp_after: got level=%0d data=%0d expected 2 5", bus.level, bus.out_data);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(tail_t[i])) begin
        n_fail++;
        $display("FAIL pp_order[%0d]: got valid=%0b data=%0d expected 1 %0d",
                 i, bus.out_valid, bus.out_data, tail_t[i]);
      end
      advance();
    end
    #4;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
      n_fail++;
      $display("FAIL pp_end: got valid=%0b level=%0d expected 0 0", bus.out_valid, bus.level);
    end
    advance();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_fib_stream();
    test_random_stall();
    test_mid_reset();
    test_push_pop_same();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fib_pair_serializer.md
Name: fib_pair_serializer

Overview:
- Consumer stage directly downstream of the double-rate Fibonacci generator.
- Accepts two W-bit numbers per beat (lo first, hi second) and buffers them as pairs in a small FIFO.
- Emits one number per beat on a valid/ready stream, in order lo, hi, lo, hi, ...
- Bridges the two-per-cycle producer to single-rate consumers such as sequence checkers and display sinks.

Parameters:
- W, 16, width of each number.
- DEPTH, 4, FIFO capacity in pairs; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  pair accepted when in_valid && in_ready.
- in_lo  input  W  first number of the pair (emitted first).
- in_hi  input  W  second number of the pair.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  W  current number.
- level  output  $clog2(DEPTH)+1  pairs currently stored.
- out_count  output  16  numbers emitted since reset; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - write/read pointers = 0, half = 0, level = 0, out_count = 0.
  - in_ready = 1, out_valid = 0.
  - FIFO storage is not reset.
- Push:
  - in_ready = (level != DEPTH); no dependence on out_ready.
  - On accept, {in_lo, in_hi} is written at the write pointer, which increments with wrap at DEPTH.
- Output:
  - out_valid = (level != 0).
  - out_data = head.lo when half == 0, else head.hi.
  - out_data is a combinational mux from storage; no input-to-output bypass.
- Pop:
  - On output handshake with half == 0: half <= 1; the entry stays in the FIFO.
  - On output handshake with half == 1: half <= 0, the read pointer increments with wrap, and level decrements.
  - Every output handshake increments out_count.
- Latency: a pair accepted at edge N shows its lo at out_data after edge N; hi follows on the next output handshake.
- Simultaneous push and pair-completing pop in one cycle: level is unchanged and both pointers advance.
- Full:
  - in_ready = 0 while level == DEPTH, even if a pop completes in the same cycle; no pass-through.
  - in_ready returns to 1 the cycle after the pop.
- Empty: out_valid = 0 and out_data is don't-care; half is guaranteed 0.
- Stalls:
  - out_data, out_valid and half hold while out_ready = 0.
  - Upstream holds in_lo/in_hi while in_valid && !in_ready; the block does not check this.
- Throughput:
  - Sustained input is one pair per two cycles.
  - Output is one number per cycle whenever level != 0 and out_ready = 1.
- Pointer width is $clog2(DEPTH); level carries the extra bit that distinguishes full from empty.
- Reset asserted mid-stream: all buffered pairs are discarded immediately and the block returns to its reset values.
- No overflow or underflow is possible by construction. The internal assertions below check this.
  - No write while level == DEPTH.
  - No read while level == 0.

Decomposition:
- Package fib_pkg holds:
  - localparam FIB_W = 16.
  - typedef fib_pair_t as a packed struct {logic [FIB_W-1:0] hi; logic [FIB_W-1:0] lo;}.
- Sub-module fib_pair_fifo: a synchronous FIFO of fib_pair_t with ports push, pop, full, empty, level, wdata and rdata.
- The top level adds only the half flag, the output mux and out_count.

Test Plan:
- Reset, then no stimulus -> in_ready = 1, out_valid = 0, level = 0, out_count = 0.
- Push pairs (1,1), (2,3), (5,8), (13,21) back-to-back with out_ready = 0 -> level reaches 4 and in_ready = 0 after the 4th accept. Then out_ready = 1 -> out_data sequence 1,1,2,3,5,8,13,21 over 8 cycles, and in_ready rises the cycle after the first pair completes.
- fibonacci_2 connected upstream, out_ready = 1, 20 numbers compared against single-rate fibonacci -> exact match 1,1,2,3,...,6765; out_count = 20.
- out_ready toggled by a random 50% pattern -> no number dropped or duplicated, and out_data stable across every stall cycle.
- Reset asserted with level = 3 and half = 1 -> out_valid falls at once, level = 0. After release, pushing (89,144) gives outputs 89 then 144.
- Push and pair-completing pop in the same cycle at level = 2 -> level stays 2 and ordering is preserved.
